// File: rtl/serial_parity_rx.sv
// serial_parity_rx
//   Receives framed, LSB-first serial words from a single idle-high line and
//   samples each bit near its middle using a local clock. When PARITY_CHECK_EN
//   is defined, each frame carries an even-parity bit after the data bits, and
//   that bit is checked. Each word is presented with a one-cycle valid strobe.
//
//   Frame: start(0), DATA_W data bits LSB first, [parity], stop(1).
//
//   Build option: `define PARITY_CHECK_EN adds the parity bit and its check.
//   Without it, the frame has no parity bit and parity_err is tied to 0.
//
// Parameters
//   DATA_W        data bits per frame (1-16)
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   rx          serial line, asynchronous to clk
//   data_out    last received word
//   valid       one-cycle strobe; data_out and the error flags update with it
//   parity_err  last word failed the even-parity check
//   frame_err   last word had its stop bit sampled low
//   busy        receiver is inside a frame (FSM not idle)
module serial_parity_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PARITY_CHECK_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                rx_meta;
    logic                rxs;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic                tick;
    logic                shift_en;
    logic                stop_smp;
    logic [DATA_W-1:0]   shreg;
`ifdef PARITY_CHECK_EN
    logic                par_smp;
    logic                par_bit;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rxs) state_next = START;
            // Re-check the line half a bit in; a high level means a glitch.
            START: if (tick) state_next = rxs ? IDLE : DATA;
            DATA:  if (tick && bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                       state_next = PARITY;
`else
                       state_next = STOP;
`endif
                   end
`ifdef PARITY_CHECK_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP:  if (tick) state_next = rxs ? IDLE : BRK;
            // A held-low line (break) blocks new frames until it goes high.
            BRK:   if (rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        busy     = (state != IDLE);
        // START waits half a bit to land mid-bit; later states wait whole bits.
        tick     = (state == START) ? (baud_cnt == HALF_LAST) : (baud_cnt == FULL_LAST);
        shift_en = (state == DATA) && tick;
        stop_smp = (state == STOP) && tick;
`ifdef PARITY_CHECK_EN
        par_smp  = (state == PARITY) && tick;
`endif
    end

    // Baud and bit counters restart on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_next != state) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            if (shift_en) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Shift register fills from the top so the first (LSB) bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= DATA_W'({rxs, shreg} >> 1);
`ifdef PARITY_CHECK_EN
        if (par_smp) par_bit <= rxs;
`endif
    end

    // Word and flags are captured together on the stop-bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            data_out  <= '0;
            frame_err <= 1'b0;
        end else begin
            valid <= stop_smp;
            if (stop_smp) begin
                data_out  <= shreg;
                frame_err <= ~rxs;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        parity_err <= 1'b0;
        else if (stop_smp) parity_err <= (^shreg) ^ par_bit;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
